// File: rtl/fan_pkg.sv
//------------------------------------------------------------------
// fan_pkg -- speed/mode encodings and FSM state type. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

package fan_pkg;

   localparam logic [1:0] SPD_STOP = 2'd0;
   localparam logic [1:0] SPD_LOW  = 2'd1;
   localparam logic [1:0] SPD_MID  = 2'd2;
   localparam logic [1:0] SPD_HIGH = 2'd3;

   localparam logic [1:0] MODE_NORMAL  = 2'd0;
   localparam logic [1:0] MODE_NATURAL = 2'd1;
   localparam logic [1:0] MODE_SLEEP   = 2'd2;

   typedef enum logic {
      ST_OFF = 1'b0,
      ST_RUN = 1'b1
   } fan_state_t;

   function automatic logic [1:0] next_speed(input logic [1:0] spd);
      return (spd == SPD_HIGH) ? SPD_LOW : 2'(spd + 2'd1);
   endfunction

   function automatic logic [1:0] next_mode(input logic [1:0] mode);
      case (mode)
         MODE_NORMAL:  return MODE_NATURAL;
         MODE_NATURAL: return MODE_SLEEP;
         default:      return MODE_NORMAL;
      endcase
   endfunction

   // Natural-wind pattern: low, mid, high, mid
   function automatic logic [1:0] nat_level(input logic [1:0] idx);
      case (idx)
         2'd0:    return SPD_LOW;
         2'd2:    return SPD_HIGH;
         default: return SPD_MID;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/autooff_countdown.sv
//------------------------------------------------------------------
// autooff_countdown -- auto-off preset, countdown, expiry and blink. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module autooff_countdown
   import fan_pkg::*;
#(
   parameter int TIMER_STEP  = 60,
   parameter int TIMER_STEPS = 3,
   parameter int REM_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   input  logic             key_timer,
   input  logic             tick_1s,
   input  logic             tick_250ms,
   output logic [REM_W-1:0] remain_s,
   output logic             warn_blink,
   output logic             expire
);

   localparam int IDX_W = $clog2(TIMER_STEPS + 1);

   logic [IDX_W-1:0] preset;
   logic [IDX_W-1:0] preset_nxt;
   logic [REM_W-1:0] remain_nxt;
   logic             blink_nxt;
   logic             in_window;

   always_comb begin
      preset_nxt = preset;
      remain_nxt = remain_s;
      expire     = 1'b0;
      if (clear) begin
         preset_nxt = '0;
         remain_nxt = '0;
      end else if (enable) begin
         // A timer key outranks expiry: reloading keeps the fan running
         if (key_timer) begin
            preset_nxt = (preset == IDX_W'(TIMER_STEPS)) ? '0 : preset + IDX_W'(1);
            remain_nxt = REM_W'(preset_nxt) * REM_W'(TIMER_STEP);
         end else if (tick_1s && (remain_s != '0)) begin
            remain_nxt = remain_s - REM_W'(1);
            expire     = (remain_s == REM_W'(1));
         end
      end
      in_window = (remain_nxt != '0) && (remain_nxt <= REM_W'(10));
      blink_nxt = in_window ? (warn_blink ^ (enable & tick_250ms)) : 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         preset     <= '0;
         remain_s   <= '0;
         warn_blink <= 1'b0;
      end else begin
         preset     <= preset_nxt;
         remain_s   <= remain_nxt;
         warn_blink <= blink_nxt;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fan_mode_scheduler.sv
//------------------------------------------------------------------
// fan_mode_scheduler -- power FSM, user speed, wind mode sequencing. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module fan_mode_scheduler
   import fan_pkg::*;
#(
   parameter int TIMER_STEP  = 60,
   parameter int TIMER_STEPS = 3,
   parameter int NAT_HOLD    = 4,
   parameter int SLEEP_HOLD  = 10,
   parameter int REM_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_power,
   input  logic             key_speed,
   input  logic             key_mode,
   input  logic             key_timer,
   input  logic             tick_1s,
   input  logic             tick_250ms,
   output logic             fan_on,
   output logic [1:0]       speed_out,
   output logic [1:0]       mode_out,
   output logic [REM_W-1:0] remain_s,
   output logic             warn_blink
);

   localparam int HOLD_MAX = (NAT_HOLD > SLEEP_HOLD) ? NAT_HOLD : SLEEP_HOLD;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

   fan_state_t        state;
   fan_state_t        state_nxt;
   logic [1:0]        user_spd, user_nxt;
   logic [1:0]        mode, mode_nxt;
   logic [1:0]        nat_idx, nat_nxt;
   logic [1:0]        sleep_lvl, sleep_nxt;
   logic [1:0]        speed_nxt;
   logic [HOLD_W-1:0] hold, hold_nxt;
   logic              in_run;
   logic              cd_enable;
   logic              expire;

   assign in_run    = (state == ST_RUN);
   assign cd_enable = in_run && !key_power;
   assign fan_on    = in_run;
   assign mode_out  = mode;

   autooff_countdown #(
      .TIMER_STEP  (TIMER_STEP),
      .TIMER_STEPS (TIMER_STEPS),
      .REM_W       (REM_W)
   ) u_countdown (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (key_power),
      .enable     (cd_enable),
      .key_timer  (key_timer),
      .tick_1s    (tick_1s),
      .tick_250ms (tick_250ms),
      .remain_s   (remain_s),
      .warn_blink (warn_blink),
      .expire     (expire)
   );

   always_comb begin
      state_nxt = state;
      user_nxt  = user_spd;
      mode_nxt  = mode;
      nat_nxt   = nat_idx;
      sleep_nxt = sleep_lvl;
      hold_nxt  = hold;
      // Both power transitions start from the same clean internal state
      if (key_power || expire) begin
         state_nxt = in_run ? ST_OFF : ST_RUN;
         user_nxt  = SPD_LOW;
         mode_nxt  = MODE_NORMAL;
         nat_nxt   = 2'd0;
         sleep_nxt = SPD_LOW;
         hold_nxt  = '0;
      end else if (in_run) begin
         if (tick_1s) begin
            case (mode)
               MODE_NATURAL: begin
                  if (hold == HOLD_W'(NAT_HOLD - 1)) begin
                     hold_nxt = '0;
                     nat_nxt  = 2'(nat_idx + 2'd1);
                  end else begin
                     hold_nxt = hold + HOLD_W'(1);
                  end
               end
               MODE_SLEEP: begin
                  if (hold == HOLD_W'(SLEEP_HOLD - 1)) begin
                     hold_nxt = '0;
                     if (sleep_lvl > SPD_LOW) sleep_nxt = 2'(sleep_lvl - 2'd1);
                  end else begin
                     hold_nxt = hold + HOLD_W'(1);
                  end
               end
               default: hold_nxt = hold;
            endcase
         end
         if (key_speed) begin
            user_nxt = next_speed(user_spd);
            if (mode == MODE_SLEEP) hold_nxt = '0;
         end
         if (key_mode) begin
            mode_nxt  = next_mode(mode);
            nat_nxt   = 2'd0;
            hold_nxt  = '0;
            sleep_nxt = user_nxt;
         end
      end

      speed_nxt = SPD_STOP;
      if (state_nxt == ST_RUN) begin
         case (mode_nxt)
            MODE_NATURAL: speed_nxt = nat_level(nat_nxt);
            MODE_SLEEP:   speed_nxt = sleep_nxt;
            default:      speed_nxt = user_nxt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_OFF;
         user_spd  <= SPD_STOP;
         mode      <= MODE_NORMAL;
         nat_idx   <= 2'd0;
         sleep_lvl <= SPD_STOP;
         hold      <= '0;
         speed_out <= SPD_STOP;
      end else begin
         state     <= state_nxt;
         user_spd  <= user_nxt;
         mode      <= mode_nxt;
         nat_idx   <= nat_nxt;
         sleep_lvl <= sleep_nxt;
         hold      <= hold_nxt;
         speed_out <= speed_nxt;
      end
   end

endmodule

`default_nettype wire

// File: doc/fan_mode_scheduler.md
# fan_mode_scheduler

Central sequencer of the fan controller. It consumes debounced single-cycle key pulses and the single-cycle tick pulses from the system timer block, all in the 100 Hz clock domain. It owns the power state, user speed, and wind mode (normal / natural / sleep), and the auto-off countdown. It drives the effective speed level to the motor PWM stage and the countdown and blink status to the display stage.

## Interface
- `TIMER_STEP`, default 60: seconds added per auto-off preset step.
- `TIMER_STEPS`, default 3: number of non-zero presets. Presets are 0, 1×, 2×, 3× `TIMER_STEP`.
- `NAT_HOLD`, default 4: seconds each natural-wind pattern step is held.
- `SLEEP_HOLD`, default 10: seconds between sleep-mode speed decrements.
- `REM_W`, default 8: countdown width. Must satisfy TIMER_STEP×TIMER_STEPS < 2^REM_W.
- `clk`, in, 1: 100 Hz system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `key_power`, in, 1: one-cycle pulse that toggles power.
- `key_speed`, in, 1: one-cycle pulse that advances the user speed low→mid→high→low.
- `key_mode`, in, 1: one-cycle pulse that advances the mode normal→natural→sleep→normal.
- `key_timer`, in, 1: one-cycle pulse that advances the auto-off preset, wrapping to 0.
- `tick_1s`, in, 1: one-cycle 1 s pulse.
- `tick_250ms`, in, 1: one-cycle 250 ms pulse.
- `fan_on`, out, 1: power state.
- `speed_out`, out, 2: effective level. 0 = stop, 1 = low, 2 = mid, 3 = high.
- `mode_out`, out, 2: 0 = normal, 1 = natural, 2 = sleep.
- `remain_s`, out, REM_W: seconds remaining on the auto-off countdown. 0 means the countdown is inactive.
- `warn_blink`, out, 1: blink for the last 10 s of the countdown.

## Operation
- Top FSM has two states, OFF and RUN.
- In OFF:
  - Only `key_power` is honoured. It moves the FSM to RUN.
  - Entering RUN sets user speed to low, mode to normal, preset index to 0, `remain_s` to 0, and clears the step and hold counters.
- In RUN:
  - `key_power` moves the FSM to OFF.
  - `key_speed` advances the user speed and clears the sleep hold counter.
  - `key_mode` advances the mode, clears the pattern index and hold counter, and sets sleep level = user speed.
  - `key_timer` advances the preset index p, with p=TIMER_STEPS wrapping to 0. It then loads `remain_s` with p×TIMER_STEP.
- Effective speed:
  - Normal: speed = user speed.
  - Natural: repeating pattern low, mid, high, mid. The index advances after NAT_HOLD `tick_1s` pulses.
  - Sleep: the level decrements by one every SLEEP_HOLD `tick_1s` pulses. It holds at low and never goes to 0.
- Countdown:
  - While `remain_s` is nonzero, each `tick_1s` decrements it.
  - When it decrements from 1 to 0, the FSM goes to OFF in the same update.
- Blink:
  - `warn_blink` toggles on `tick_250ms` while 0 < `remain_s` ≤ 10.
  - It is forced to 0 otherwise.
- Priority within one cycle: `key_power` > `key_timer` > countdown expiry > the other keys and ticks.
  - A `key_timer` pulse in the same cycle as expiry reloads the countdown and the fan stays on.
  - `key_speed` and `key_mode` in the same cycle are both applied.
- Arithmetic:
  - All counters are unsigned and wrap only as specified.
  - The hold counters are width clog2(max(NAT_HOLD, SLEEP_HOLD)+1).

## Timing
- Reset values:
  - `fan_on`=0, `speed_out`=0, `mode_out`=0, `remain_s`=0, `warn_blink`=0.
  - Internal state is OFF, with all counters 0.
- All outputs are registered. An input pulse in cycle N is visible on the outputs in cycle N+1.
- In OFF: `speed_out`=0 and `mode_out`=0. Ticks are ignored.
- Natural step timing: the first index change occurs on the NAT_HOLD-th `tick_1s` after the mode is entered.
- Reset asserted mid-run: all outputs go to their reset values immediately (asynchronous). Deassertion leaves the block in OFF.
- Keys that arrive while `rst_n`=0 are lost.

## Structure
- Shared package `fan_pkg` holds:
  - The speed encodings (SPD_STOP, SPD_LOW, SPD_MID, SPD_HIGH).
  - The mode encodings (MODE_NORMAL, MODE_NATURAL, MODE_SLEEP).
  - The FSM state type.
- One sub-module, `autooff_countdown`, owns the preset index, `remain_s`, the expiry pulse, and `warn_blink`.
- The parent owns the FSM, mode, and speed logic.

## Test plan
- Reset, then `key_power` → in the next cycle `fan_on`=1, `speed_out`=1, `mode_out`=0, `remain_s`=0.
- RUN, 3× `key_speed` → `speed_out` sequence is 2, 3, 1. A `key_power` then gives `fan_on`=0 and `speed_out`=0.
- RUN, `key_mode` to natural, then 16 `tick_1s` → `speed_out` sequence is 1, 2, 3, 2, changing after ticks 4, 8, 12, and returning to 1 after tick 16.
- RUN at high, sleep mode, then 25 `tick_1s` → `speed_out` goes 3→2 at tick 10, 2→1 at tick 20, and stays 1.
- With the defaults, `key_timer` → `remain_s`=60. After 50 `tick_1s`, `warn_blink` toggles on `tick_250ms`. At the 60th tick, `fan_on`=0 and `remain_s`=0.
- Set `remain_s`=1. Apply `key_timer` in the same cycle as `tick_1s` → the fan stays on with `remain_s`=120. Assert `rst_n`=0 mid-count → all outputs are 0 immediately.
